// File: rtl/usb_buf_pkg.sv
// ---------------------------------------------------------------------------
// usb_buf_pkg
// Shared constants and types for the USB endpoint data buffer.
//   DEFAULT_DEPTH      default buffer capacity in bytes
//   DEFAULT_BUS_BYTES  default widest word transfer on the bus side
//   size_width()       width of the data_size field for a given bus width
//   data_size_t        data_size field type for the default bus width
// ---------------------------------------------------------------------------
package usb_buf_pkg;

    localparam int DEFAULT_DEPTH     = 64;
    localparam int DEFAULT_BUS_BYTES = 4;

    // data_size encodes length-1, so it needs clog2(BUS_BYTES) bits, but a
    // one-byte bus still keeps a single-bit field so the port never vanishes.
    function automatic int size_width(input int bus_bytes);
        return (bus_bytes > 1) ? $clog2(bus_bytes) : 1;
    endfunction

    localparam int DEFAULT_SW = size_width(DEFAULT_BUS_BYTES);

    typedef logic [DEFAULT_SW-1:0] data_size_t;

endpackage

// File: rtl/buf_regfile.sv
// ---------------------------------------------------------------------------
// buf_regfile
// DEPTH x 8 byte store for the circular data buffer.
// Ports:
//   clk       rising-edge clock
//   wr_en     write wr_count bytes of wr_data starting at wr_ptr
//   wr_ptr    first byte address of the write (tail)
//   wr_count  number of bytes to write, 0..BUS_BYTES
//   wr_data   write bytes, byte 0 in [7:0]
//   rd_ptr    first byte address of the read lanes (head)
//   rd_data   BUS_BYTES combinational read lanes, lane 0 = byte at rd_ptr
// Addresses wrap modulo DEPTH on both ports.
// ---------------------------------------------------------------------------
module buf_regfile
    import usb_buf_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int BUS_BYTES = DEFAULT_BUS_BYTES,
    localparam int AW       = $clog2(DEPTH),
    localparam int CNTW     = $clog2(BUS_BYTES + 1)
)(
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_ptr,
    input  logic [CNTW-1:0]        wr_count,
    input  logic [8*BUS_BYTES-1:0] wr_data,
    input  logic [AW-1:0]          rd_ptr,
    output logic [8*BUS_BYTES-1:0] rd_data
);

    logic [7:0] mem [DEPTH];

    // Multi-byte write: lane i lands at wr_ptr+i. DEPTH is a power of two,
    // so truncating the sum to AW bits is exactly the circular wrap.
    // Contents are never reset; the top masks everything outside occupancy.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BUS_BYTES; i++) begin
                if (i < int'(wr_count)) begin
                    mem[wr_ptr + AW'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read lanes present the bytes from the head onward, wrapping the same way.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < BUS_BYTES; i++) begin
            rd_data[8*i +: 8] = mem[rd_ptr + AW'(i)];
        end
    end

endmodule

// File: rtl/param_data_buffer.sv
// ---------------------------------------------------------------------------
// param_data_buffer
// Circular byte buffer between a USB packet engine (one byte at a time) and
// a bus interface (up to BUS_BYTES per word).
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   clear                  flush contents and error flags
//   store_rx_packet_data   push rx_packet_data (1 byte)
//   rx_packet_data         byte from USB RX
//   get_rx_data            pop data_size+1 bytes to the bus side
//   data_size              transfer length minus one for both word ports
//   tx_data                word from the bus side, byte 0 in [7:0]
//   store_tx_data          push data_size+1 bytes of tx_data
//   get_tx_packet_data     pop 1 byte to USB TX
//   buffer_reserved        bus side owns the buffer; RX pushes are dropped
//   buffer_occupancy       bytes held, 0..DEPTH
//   rx_data                head data_size+1 bytes, zero-extended
//   tx_packet_data         head byte
//   almost_full            occupancy >= AF_LEVEL
//   overflow_err           sticky: a push was rejected or dropped
//   underflow_err          sticky: a pop was rejected or ignored
// ---------------------------------------------------------------------------
module param_data_buffer
    import usb_buf_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int BUS_BYTES = DEFAULT_BUS_BYTES,
    parameter int AF_LEVEL  = DEPTH - 8,
    localparam int OW       = $clog2(DEPTH) + 1,
    localparam int SW       = size_width(BUS_BYTES)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   store_rx_packet_data,
    input  logic [7:0]             rx_packet_data,
    input  logic                   get_rx_data,
    input  logic [SW-1:0]          data_size,
    input  logic [8*BUS_BYTES-1:0] tx_data,
    input  logic                   store_tx_data,
    input  logic                   get_tx_packet_data,
    input  logic                   buffer_reserved,
    output logic [OW-1:0]          buffer_occupancy,
    output logic [8*BUS_BYTES-1:0] rx_data,
    output logic [7:0]             tx_packet_data,
    output logic                   almost_full,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(BUS_BYTES + 1);
    // One bit wider than occupancy so occupancy + push count cannot wrap.
    localparam int CW   = OW + 1;

    logic [AW-1:0]          head;
    logic [AW-1:0]          tail;
    logic [CW-1:0]          occ_ext;
    logic [CW-1:0]          n_bytes;
    logic                   n_legal;

    logic                   push_en;
    logic [CW-1:0]          push_count;
    logic [8*BUS_BYTES-1:0] push_data;
    logic [CW-1:0]          pop_count;
    logic                   ovf_evt;
    logic                   udf_evt;

    logic [AW-1:0]          head_next;
    logic [AW-1:0]          tail_next;
    logic [OW-1:0]          occ_next;
    logic [8*BUS_BYTES-1:0] lane_data;

    assign occ_ext = CW'(buffer_occupancy);
    assign n_bytes = CW'(data_size) + CW'(1);
    assign n_legal = (n_bytes <= CW'(BUS_BYTES));

    // Push/pop arbitration. All capacity checks use the occupancy held before
    // the edge, so a pop in the same cycle never makes room for a push.
    // A losing request on either side is not merely ignored: it flags the
    // matching error so firmware can see that a byte went missing.
    always_comb begin
        push_en    = 1'b0;
        push_count = '0;
        push_data  = '0;
        pop_count  = '0;
        ovf_evt    = 1'b0;
        udf_evt    = 1'b0;

        if (store_tx_data) begin
            if (store_rx_packet_data) begin
                ovf_evt = 1'b1;
            end
            if (!n_legal || (occ_ext + n_bytes > CW'(DEPTH))) begin
                ovf_evt = 1'b1;
            end else begin
                push_en    = 1'b1;
                push_count = n_bytes;
                push_data  = tx_data;
            end
        end else if (store_rx_packet_data) begin
            if (buffer_reserved || (occ_ext + CW'(1) > CW'(DEPTH))) begin
                ovf_evt = 1'b1;
            end else begin
                push_en        = 1'b1;
                push_count     = CW'(1);
                push_data[7:0] = rx_packet_data;
            end
        end

        if (get_rx_data) begin
            if (get_tx_packet_data) begin
                udf_evt = 1'b1;
            end
            if (!n_legal || (n_bytes > occ_ext)) begin
                udf_evt = 1'b1;
            end else begin
                pop_count = n_bytes;
            end
        end else if (get_tx_packet_data) begin
            if (occ_ext == '0) begin
                udf_evt = 1'b1;
            end else begin
                pop_count = CW'(1);
            end
        end
    end

    assign head_next = head + AW'(pop_count);
    assign tail_next = tail + AW'(push_count);
    assign occ_next  = OW'(occ_ext + push_count - pop_count);

    // Pointer, occupancy and sticky error state. rst and clear both empty the
    // buffer; memory is left alone because nothing outside occupancy is
    // ever visible on the outputs.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head             <= '0;
            tail             <= '0;
            buffer_occupancy <= '0;
            overflow_err     <= 1'b0;
            underflow_err    <= 1'b0;
        end else begin
            head             <= head_next;
            tail             <= tail_next;
            buffer_occupancy <= occ_next;
            if (ovf_evt) begin
                overflow_err <= 1'b1;
            end
            if (udf_evt) begin
                underflow_err <= 1'b1;
            end
        end
    end

    buf_regfile #(
        .DEPTH     (DEPTH),
        .BUS_BYTES (BUS_BYTES)
    ) u_regfile (
        .clk      (clk),
        .wr_en    (push_en && !rst && !clear),
        .wr_ptr   (tail),
        .wr_count (CNTW'(push_count)),
        .wr_data  (push_data),
        .rd_ptr   (head),
        .rd_data  (lane_data)
    );

    // Head peeks: a lane shows data only if it is inside the requested length
    // and actually holds a byte, so stale memory never leaks out.
    always_comb begin
        rx_data = '0;
        for (int i = 0; i < BUS_BYTES; i++) begin
            if ((CW'(i) < n_bytes) && (CW'(i) < occ_ext)) begin
                rx_data[8*i +: 8] = lane_data[8*i +: 8];
            end
        end
        tx_packet_data = (occ_ext != '0) ? lane_data[7:0] : 8'h00;
    end

    assign almost_full = (occ_ext >= CW'(AF_LEVEL));

endmodule

// File: tb/tb_param_data_buffer.sv
// ---------------------------------------------------------------------------
// tb_param_data_buffer
// Directed bench for param_data_buffer at DEPTH=64, BUS_BYTES=4.
// A vector table covers single-cycle behaviour; hand sequences cover filling
// to capacity, pointer wrap, clear with errors pending and reset mid-fill.
// ---------------------------------------------------------------------------
module tb_param_data_buffer;
    import usb_buf_pkg::*;

    localparam int DEPTH     = 64;
    localparam int BUS_BYTES = 4;

    // Op bits: {rst, clear, srx, grx, stx, gtx, reserved}
    localparam logic [6:0] OP_NONE = 7'h00;
    localparam logic [6:0] OP_RST  = 7'h40;
    localparam logic [6:0] OP_CLR  = 7'h20;
    localparam logic [6:0] OP_SRX  = 7'h10;
    localparam logic [6:0] OP_GRX  = 7'h08;
    localparam logic [6:0] OP_STX  = 7'h04;
    localparam logic [6:0] OP_GTX  = 7'h02;
    localparam logic [6:0] OP_RES  = 7'h01;

    logic        tb_clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        store_rx_packet_data = 1'b0;
    logic [7:0]  rx_packet_data = 8'h00;
    logic        get_rx_data = 1'b0;
    data_size_t  data_size = '0;
    logic [31:0] tx_data = 32'h0;
    logic        store_tx_data = 1'b0;
    logic        get_tx_packet_data = 1'b0;
    logic        buffer_reserved = 1'b0;

    logic [6:0]  buffer_occupancy;
    logic [31:0] rx_data;
    logic [7:0]  tx_packet_data;
    logic        almost_full;
    logic        overflow_err;
    logic        underflow_err;

    int num_checks = 0;
    int num_fails  = 0;

    // Expected flags are packed as {almost_full, overflow_err, underflow_err}.
    typedef struct {
        string       name;
        logic [6:0]  ops;
        logic [7:0]  rxb;
        data_size_t  ds;
        logic [31:0] txd;
        logic [6:0]  e_occ;
        logic [31:0] e_rx;
        logic [7:0]  e_tx;
        logic [2:0]  e_flags;
    } vec_t;

    vec_t vecs[$];

    always #5 tb_clk = ~tb_clk;

    param_data_buffer #(
        .DEPTH     (DEPTH),
        .BUS_BYTES (BUS_BYTES),
        .AF_LEVEL  (DEPTH - 8)
    ) dut (
        .clk                  (tb_clk),
        .rst                  (rst),
        .clear                (clear),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_rx_data          (get_rx_data),
        .data_size            (data_size),
        .tx_data              (tx_data),
        .store_tx_data        (store_tx_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .buffer_reserved      (buffer_reserved),
        .buffer_occupancy     (buffer_occupancy),
        .rx_data              (rx_data),
        .tx_packet_data       (tx_packet_data),
        .almost_full          (almost_full),
        .overflow_err         (overflow_err),
        .underflow_err        (underflow_err)
    );

    function automatic vec_t mk(input string name, input logic [6:0] ops,
                                input logic [7:0] rxb, input data_size_t ds,
                                input logic [31:0] txd, input logic [6:0] e_occ,
                                input logic [31:0] e_rx, input logic [7:0] e_tx,
                                input logic [2:0] e_flags);
        vec_t v;
        v.name = name; v.ops = ops; v.rxb = rxb; v.ds = ds; v.txd = txd;
        v.e_occ = e_occ; v.e_rx = e_rx; v.e_tx = e_tx; v.e_flags = e_flags;
        return v;
    endfunction

    // Word whose bytes are 4k, 4k+1, 4k+2, 4k+3 from lane 0 upward.
    function automatic logic [31:0] fillWord(input int k);
        return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    endfunction

    // Drive one cycle of ops at the falling edge, let the rising edge take
    // them, then drop the strobes; data_size stays so the peeks can be read.
    task automatic applyStimulus(input logic [6:0] ops, input logic [7:0] rxb,
                                 input data_size_t ds, input logic [31:0] txd);
        @(negedge tb_clk);
        {rst, clear, store_rx_packet_data, get_rx_data,
         store_tx_data, get_tx_packet_data, buffer_reserved} = ops;
        rx_packet_data = rxb;
        data_size      = ds;
        tx_data        = txd;
        @(posedge tb_clk);
        #1;
        {rst, clear, store_rx_packet_data, get_rx_data,
         store_tx_data, get_tx_packet_data, buffer_reserved} = OP_NONE;
    endtask

    task automatic checkValue(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [6:0] e_occ,
                               input logic [31:0] e_rx, input logic [7:0] e_tx,
                               input logic [2:0] e_flags);
        checkValue(name, "occupancy",   32'(buffer_occupancy), 32'(e_occ));
        checkValue(name, "rx_data",     rx_data,               e_rx);
        checkValue(name, "tx_byte",     32'(tx_packet_data),   32'(e_tx));
        checkValue(name, "almost_full", 32'(almost_full),      32'(e_flags[2]));
        checkValue(name, "overflow",    32'(overflow_err),     32'(e_flags[1]));
        checkValue(name, "underflow",   32'(underflow_err),    32'(e_flags[0]));
    endtask

    initial begin
        logic [6:0]  occ;
        logic [7:0]  wrap_bytes [4];

        // Single-cycle behaviour from reset: RX fill/word read, partial
        // peeks, rejected pops, arbitration conflicts and clear priority.
        vecs.push_back(mk("reset",     OP_RST,          8'h00, 2'd0, 32'h0,        7'd0,  32'h0,        8'h00, 3'b000));
        vecs.push_back(mk("rx_a1",     OP_SRX,          8'hA1, 2'd0, 32'h0,        7'd1,  32'h000000A1, 8'hA1, 3'b000));
        vecs.push_back(mk("rx_b2",     OP_SRX,          8'hB2, 2'd1, 32'h0,        7'd2,  32'h0000B2A1, 8'hA1, 3'b000));
        vecs.push_back(mk("rx_c3",     OP_SRX,          8'hC3, 2'd2, 32'h0,        7'd3,  32'h00C3B2A1, 8'hA1, 3'b000));
        vecs.push_back(mk("pop3",      OP_GRX,          8'h00, 2'd2, 32'h0,        7'd0,  32'h0,        8'h00, 3'b000));
        vecs.push_back(mk("tx2",       OP_STX,          8'h00, 2'd1, 32'hDEAD5566, 7'd2,  32'h00005566, 8'h66, 3'b000));
        vecs.push_back(mk("udf_pop4",  OP_GRX,          8'h00, 2'd3, 32'h0,        7'd2,  32'h00005566, 8'h66, 3'b001));
        vecs.push_back(mk("gtx_1",     OP_GTX,          8'h00, 2'd3, 32'h0,        7'd1,  32'h00000055, 8'h55, 3'b001));
        vecs.push_back(mk("gtx_2",     OP_GTX,          8'h00, 2'd3, 32'h0,        7'd0,  32'h0,        8'h00, 3'b001));
        vecs.push_back(mk("clear_a",   OP_CLR,          8'h00, 2'd3, 32'h0,        7'd0,  32'h0,        8'h00, 3'b000));
        vecs.push_back(mk("gtx_empty", OP_GTX,          8'h00, 2'd3, 32'h0,        7'd0,  32'h0,        8'h00, 3'b001));
        vecs.push_back(mk("clear_b",   OP_CLR,          8'h00, 2'd3, 32'h0,        7'd0,  32'h0,        8'h00, 3'b000));
        vecs.push_back(mk("tx4_a",     OP_STX,          8'h00, 2'd3, 32'h04030201, 7'd4,  32'h04030201, 8'h01, 3'b000));
        vecs.push_back(mk("tx4_b",     OP_STX,          8'h00, 2'd3, 32'h08070605, 7'd8,  32'h04030201, 8'h01, 3'b000));
        vecs.push_back(mk("tx2_c",     OP_STX,          8'h00, 2'd1, 32'hDEAD0A09, 7'd10, 32'h00000201, 8'h01, 3'b000));
        vecs.push_back(mk("push_pop",  OP_SRX|OP_GRX,   8'h0B, 2'd3, 32'h0,        7'd7,  32'h08070605, 8'h05, 3'b000));
        vecs.push_back(mk("reserved",  OP_SRX|OP_RES,   8'hEE, 2'd3, 32'h0,        7'd7,  32'h08070605, 8'h05, 3'b010));
        vecs.push_back(mk("clear_c",   OP_CLR,          8'h00, 2'd0, 32'h0,        7'd0,  32'h0,        8'h00, 3'b000));
        vecs.push_back(mk("both_push", OP_STX|OP_SRX,   8'h88, 2'd0, 32'h00000077, 7'd1,  32'h00000077, 8'h77, 3'b010));
        vecs.push_back(mk("rx_99",     OP_SRX,          8'h99, 2'd0, 32'h0,        7'd2,  32'h00000077, 8'h77, 3'b010));
        vecs.push_back(mk("both_pop",  OP_GRX|OP_GTX,   8'h00, 2'd0, 32'h0,        7'd1,  32'h00000099, 8'h99, 3'b011));
        vecs.push_back(mk("clear_ops", OP_CLR|OP_STX,   8'h00, 2'd3, 32'h12345678, 7'd0,  32'h0,        8'h00, 3'b000));

        $display("[TB] applying %0d table vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ops, vecs[i].rxb, vecs[i].ds, vecs[i].txd);
            checkOutput(vecs[i].name, vecs[i].e_occ, vecs[i].e_rx, vecs[i].e_tx, vecs[i].e_flags);
        end

        // Fill to capacity with word stores; almost_full turns on at 56.
        $display("[TB] fill sequence");
        for (int k = 0; k < 16; k++) begin
            applyStimulus(OP_STX, 8'h00, 2'd3, fillWord(k));
            occ = 7'(4 * (k + 1));
            checkOutput($sformatf("fill_%0d", k), occ, 32'h03020100, 8'h00,
                        {(occ >= 7'd56), 2'b00});
        end
        applyStimulus(OP_STX, 8'h00, 2'd3, 32'hFFFFFFFF);
        checkOutput("fill_over", 7'd64, 32'h03020100, 8'h00, 3'b110);
        // Full buffer: the push is judged on pre-edge occupancy and fails,
        // the pop still goes through.
        applyStimulus(OP_STX|OP_GTX, 8'h00, 2'd0, 32'h000000AA);
        checkOutput("full_push_pop", 7'd63, 32'h00000001, 8'h01, 3'b110);

        // Advance the pointers to 62, then store a word straddling 63/0.
        $display("[TB] wrap sequence");
        applyStimulus(OP_CLR, 8'h00, 2'd0, 32'h0);
        checkOutput("wrap_clear", 7'd0, 32'h0, 8'h00, 3'b000);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(OP_STX, 8'h00, 2'd3, fillWord(k + 16));
            checkOutput($sformatf("wrap_st_%0d", k), 7'd4, fillWord(k + 16),
                        8'(4 * (k + 16)), 3'b000);
            applyStimulus(OP_GRX, 8'h00, 2'd3, 32'h0);
            checkOutput($sformatf("wrap_pop_%0d", k), 7'd0, 32'h0, 8'h00, 3'b000);
        end
        for (int j = 0; j < 2; j++) begin
            applyStimulus(OP_SRX, 8'(8'hE0 + j), 2'd0, 32'h0);
            checkOutput($sformatf("wrap_rx_%0d", j), 7'd1, 32'(8'hE0 + j), 8'(8'hE0 + j), 3'b000);
            applyStimulus(OP_GTX, 8'h00, 2'd0, 32'h0);
            checkOutput($sformatf("wrap_gtx_%0d", j), 7'd0, 32'h0, 8'h00, 3'b000);
        end
        applyStimulus(OP_STX, 8'h00, 2'd3, 32'h44332211);
        checkOutput("wrap_store", 7'd4, 32'h44332211, 8'h11, 3'b000);
        wrap_bytes[0] = 8'h22;
        wrap_bytes[1] = 8'h33;
        wrap_bytes[2] = 8'h44;
        wrap_bytes[3] = 8'h00;
        for (int p = 0; p < 4; p++) begin
            applyStimulus(OP_GTX, 8'h00, 2'd0, 32'h0);
            checkOutput($sformatf("wrap_out_%0d", p), 7'(3 - p), 32'(wrap_bytes[p]),
                        wrap_bytes[p], 3'b000);
        end

        // Clear with both error flags pending and 20 bytes held.
        $display("[TB] clear sequence");
        applyStimulus(OP_GTX, 8'h00, 2'd3, 32'h0);
        checkOutput("clr_udf", 7'd0, 32'h0, 8'h00, 3'b001);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(OP_STX, 8'h00, 2'd3, fillWord(k));
        end
        checkOutput("clr_fill20", 7'd20, 32'h03020100, 8'h00, 3'b001);
        applyStimulus(OP_SRX|OP_RES, 8'h5A, 2'd3, 32'h0);
        checkOutput("clr_ovf", 7'd20, 32'h03020100, 8'h00, 3'b011);
        applyStimulus(OP_CLR, 8'h00, 2'd3, 32'h0);
        checkOutput("clr_done", 7'd0, 32'h0, 8'h00, 3'b000);

        // Reset arriving mid-fill, together with clear and live ops.
        $display("[TB] reset mid-fill");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(OP_STX, 8'h00, 2'd3, fillWord(k));
        end
        applyStimulus(OP_SRX|OP_RES, 8'h5A, 2'd3, 32'h0);
        checkOutput("rst_pre", 7'd12, 32'h03020100, 8'h00, 3'b010);
        applyStimulus(OP_RST|OP_CLR|OP_STX|OP_GRX, 8'h00, 2'd3, 32'hCAFEF00D);
        checkOutput("rst_mid", 7'd0, 32'h0, 8'h00, 3'b000);
        applyStimulus(OP_STX, 8'h00, 2'd3, fillWord(5));
        checkOutput("rst_after", 7'd4, fillWord(5), 8'h14, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
